// File: rtl/seq_addsub.sv
`default_nettype none
`timescale 1ns/1ps
//----------------------------------------------------------------------------
// Module   : seq_addsub
// Brief    : Multi-cycle adder/subtractor, CHUNK bits per clock, WIDTH/CHUNK
//            cycles per operation. Optional overflow flag: SEQ_ADDSUB_OVF_EN.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             busy,
  output logic             done
);

  // WIDTH must be a non-zero multiple of CHUNK.
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  always_comb begin
    chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
              + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (state_q == RUN) && (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          co_d    = chunk_sum[CHUNK];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_ADDSUB_OVF_EN
  logic v_q, v_d;

  // Sign of the final result is the top bit of the last chunk being written.
  always_comb begin
    v_d = v_q;
    if (last_chunk)
      v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign V = v_q;
`else
  assign V = 1'b0;
`endif

  assign S    = s_q;
  assign Co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
`timescale 1ns/1ps
//----------------------------------------------------------------------------
// Module   : tb_seq_addsub
// Brief    : Self-checking bench for seq_addsub (WIDTH=16, CHUNK=4) with a
//            signed/unsigned arithmetic reference model.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_seq_addsub;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

`ifdef SEQ_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .S     (S),
    .Co    (Co),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: two's-complement add/sub evaluated with plain integer maths.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] es, output logic eco, output logic ev);
    int sa, sb, sr;
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      es  = 16'((ua - ub) & 32'hFFFF);
      eco = (ua >= ub);
      sr  = sa - sb;
    end else begin
      es  = 16'((ua + ub) & 32'hFFFF);
      eco = ((ua + ub) > 32'hFFFF);
      sr  = sa + sb;
    end
    ev = OVF_EN && ((sr > 32767) || (sr < -32768));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; with 'poke' the inputs are scrambled during RUN and a
  // second start is raised two cycles after the accepted one.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input bit poke);
    logic [15:0] es;
    logic        eco, ev;
    int          cyc;
    model(a, b, s, es, eco, ev);
    A = a; B = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      if (poke) begin
        A     = 16'($urandom);
        B     = 16'($urandom);
        sub   = 1'($urandom);
        start = (cyc == 1);
      end
      if (busy && done) check({tag, "_overlap"}, 32'd1, 32'd0);
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_S"}, {16'd0, S}, {16'd0, es});
    check({tag, "_Co"}, {31'd0, Co}, {31'd0, eco});
    check({tag, "_V"}, {31'd0, V}, {31'd0, ev});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_S_hold"}, {16'd0, S}, {16'd0, es});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    #1;
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_flags", {28'd0, Co, V, busy, done}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Directed cases; the first start lands on the first edge after reset.
    do_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("8000_minus_1", 16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op("7fff_plus_1_ignore", 16'h7FFF, 16'h0001, 1'b0, 1'b1);

    // Reset aborts a running operation.
    A = 16'h1234; B = 16'h1111; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_S", {16'd0, S}, 32'd0);
    check("abort_flags", {28'd0, Co, V, busy, done}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) check("abort_no_done", {30'd0, busy, done}, 32'd0);
    end
    check("abort_idle_S", {16'd0, S}, 32'd0);
    do_op("3_minus_5", 16'h0003, 16'h0005, 1'b1, 1'b0);

    // Back-to-back with start held high.
    begin
      int last, ndone;
      last = -1; ndone = 0;
      A = 16'h0001; B = 16'h0001; sub = 1'b0; start = 1'b1;
      for (int c = 0; c < 32; c++) begin
        tick();
        check("b2b_no_overlap", {31'd0, busy && done}, 32'd0);
        if (done) begin
          if (last >= 0) check("b2b_period", c - last, 5);
          check("b2b_S", {16'd0, S}, 32'h0002);
          last = c;
          ndone++;
        end
      end
      start = 1'b0;
      check("b2b_count", {31'd0, ndone >= 5}, 32'd1);
      for (int c = 0; c < 10 && (busy || done); c++) tick();
      check("b2b_idle", {30'd0, busy, done}, 32'd0);
    end

    // Randomized operations with input disturbance during RUN.
    for (int i = 0; i < 40; i++)
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    // Boundary operands.
    do_op("0_minus_0", 16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op("8000_plus_8000", 16'h8000, 16'h8000, 1'b0, 1'b0);
    do_op("7fff_minus_ffff", 16'h7FFF, 16'hFFFF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be an integer multiple of CHUNK, minimum CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 sub  input  1  0 = A+B, 1 = A-B (two's complement); sampled with start.
REQ-007 A  input  WIDTH  operand A; sampled with start.
REQ-008 B  input  WIDTH  operand B; sampled with start.
REQ-009 S  output  WIDTH  registered sum/difference.
REQ-010 Co  output  1  registered carry out of MSB; in subtract mode, 1 = no borrow.
REQ-011 V  output  1  registered signed-overflow flag (see Configuration).
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse when S/Co/V are valid for a new result.

Function
REQ-014 FSM SHALL have exactly two states: IDLE, RUN; N = WIDTH/CHUNK.
REQ-015 IDLE and start=1 at an edge: latch A, B XOR {WIDTH{sub}}, carry register = sub, chunk index = 0; go to RUN; busy=1 from the next cycle.
REQ-016 Each RUN edge SHALL add chunk k of the latched operands plus the carry register, write the CHUNK-bit result into S-bit range k, update carry, increment k.
REQ-017 On the RUN edge processing chunk N-1: Co = final carry, V updated, done=1 for exactly one cycle, busy=0, state -> IDLE.
REQ-018 Latency: done SHALL be high exactly N cycles after the edge sampling start (4 for defaults); throughput one operation per N+1 cycles minimum.
REQ-019 start while busy=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-020 start high in the cycle done is high SHALL be accepted (state is IDLE then).
REQ-021 A, B, sub changes during RUN SHALL NOT affect the result.
REQ-022 S, Co, V SHALL hold their last values until the next completion; only upper chunks not yet processed MAY retain old values while busy=1.
REQ-023 done and busy SHALL never be high simultaneously.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; S = A+B or A+~B+1 with no width extension.

Reset
REQ-025 reset=1 SHALL immediately force state=IDLE, S=0, Co=0, V=0, busy=0, done=0, chunk index=0, carry register=0.
REQ-026 reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-027 First start SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro SEQ_ADDSUB_OVF_EN defined: V = (MSB of latched A == MSB of latched modified B) AND (MSB of S != that MSB), registered at completion.
REQ-029 Macro SEQ_ADDSUB_OVF_EN undefined: V port SHALL remain present and be constant 0; no overflow logic SHALL be synthesised.

Verification (WIDTH=16, CHUNK=4, macro defined unless stated)
REQ-030 start, sub=0, A=0xFFFF, B=0x0001 -> 4 cycles later done=1, S=0x0000, Co=1, V=0.
REQ-031 start, sub=1, A=0x8000, B=0x0001 -> S=0x7FFF, Co=1, V=1; same stimulus with macro undefined -> V=0.
REQ-032 start, sub=0, A=0x7FFF, B=0x0001, then start with A=0x0000 two cycles later -> second start ignored; S=0x8000, Co=0, V=1.
REQ-033 start (0x1234+0x1111), reset pulse two cycles later -> all outputs 0 immediately, no done; new start 0x0003-0x0005 -> S=0xFFFE, Co=0.
REQ-034 Back-to-back: start held high continuously with 0x0001+0x0001 -> done every 5 cycles, S=0x0002, busy never overlaps done.
